// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axil_pkg
//  Description : Shared AXI4-Lite response codes and an index-width helper
//                for the register file.
//  Revision    : 1.0 - initial release
// ============================================================================
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Bits needed to select one of n registers; never narrower than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axil_regfile_wr.sv
`default_nettype none
// ============================================================================
//  Module      : axil_regfile_wr
//  Description : AXI4-Lite write channel engine. Captures AW and W
//                independently, raises a one-cycle commit strobe once both
//                are available, and owns the B response registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module axil_regfile_wr
  import axil_pkg::*;
#(
  parameter int C_DATA_W = 32,
  parameter int C_ADDR_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [C_ADDR_W-1:2]   awaddr_i,
  input  logic                  awvalid_i,
  output logic                  awready_o,
  input  logic [C_DATA_W-1:0]   wdata_i,
  input  logic [C_DATA_W/8-1:0] wstrb_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  output logic [1:0]            bresp_o,
  output logic                  bvalid_o,
  input  logic                  bready_i,
  output logic                  commit_o,
  output logic [C_ADDR_W-1:2]   commit_addr_o,
  output logic [C_DATA_W-1:0]   commit_data_o,
  output logic [C_DATA_W/8-1:0] commit_strb_o,
  input  logic [1:0]            commit_resp_i
);

  logic                  aw_held_q, aw_held_d;
  logic [C_ADDR_W-1:2]   awaddr_q,  awaddr_d;
  logic                  w_held_q,  w_held_d;
  logic [C_DATA_W-1:0]   wdata_q,   wdata_d;
  logic [C_DATA_W/8-1:0] wstrb_q,   wstrb_d;
  logic                  bvalid_q,  bvalid_d;
  logic [1:0]            bresp_q,   bresp_d;

  logic w_aw_hs;
  logic w_wd_hs;

  // Both channels stall while a response is outstanding so only one write
  // is ever in flight.
  assign awready_o = !aw_held_q && !bvalid_q;
  assign wready_o  = !w_held_q  && !bvalid_q;
  assign w_aw_hs   = awvalid_i && awready_o;
  assign w_wd_hs   = wvalid_i  && wready_o;

  // A channel counts as present if it is held from earlier or handshaking
  // now; the live bus value is used in the latter case so AW+W on the same
  // edge commits without an extra cycle.
  assign commit_o      = (aw_held_q || w_aw_hs) && (w_held_q || w_wd_hs);
  assign commit_addr_o = aw_held_q ? awaddr_q : awaddr_i;
  assign commit_data_o = w_held_q  ? wdata_q  : wdata_i;
  assign commit_strb_o = w_held_q  ? wstrb_q  : wstrb_i;

  assign bvalid_o = bvalid_q;
  assign bresp_o  = bresp_q;

  // Next-state for capture flags, capture registers and the B response.
  always_comb begin
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;

    if (w_aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = awaddr_i;
    end
    if (w_wd_hs) begin
      w_held_d = 1'b1;
      wdata_d  = wdata_i;
      wstrb_d  = wstrb_i;
    end
    if (bvalid_q && bready_i) begin
      bvalid_d = 1'b0;
    end
    if (commit_o) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = commit_resp_i;
    end
  end

  // State registers; reset drops any half-captured transaction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axil_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : axil_regfile
//  Description : AXI4-Lite slave exposing C_NUM_RW read/write control words
//                followed by C_NUM_RO read-only status words. Write channel
//                handling lives in axil_regfile_wr; decode, storage and the
//                read channel live here.
//  Revision    : 1.0 - initial release
// ============================================================================
module axil_regfile
  import axil_pkg::*;
#(
  parameter int C_DATA_W = 32,
  parameter int C_ADDR_W = 32,
  parameter int C_NUM_RW = 8,
  parameter int C_NUM_RO = 4
) (
  input  logic                           s_axi_aclk,
  input  logic                           s_axi_areset,
  input  logic [C_ADDR_W-1:0]            s_axi_awaddr,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [C_DATA_W-1:0]            s_axi_wdata,
  input  logic [C_DATA_W/8-1:0]          s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [C_ADDR_W-1:0]            s_axi_araddr,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [C_DATA_W-1:0]            s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic [C_NUM_RW*C_DATA_W-1:0]   ctrl_out,
  output logic [C_NUM_RW-1:0]            ctrl_wr_stb,
  input  logic [C_NUM_RO*C_DATA_W-1:0]   status_in
);

  localparam int NUM_REGS = C_NUM_RW + C_NUM_RO;
  localparam int IDX_W    = clog2(NUM_REGS);
  localparam int WIDX_W   = C_ADDR_W - 2;
  localparam int NBYTES   = C_DATA_W / 8;

  localparam logic [WIDX_W-1:0] RW_END  = WIDX_W'(C_NUM_RW);
  localparam logic [WIDX_W-1:0] MAP_END = WIDX_W'(NUM_REGS);

  if (C_DATA_W != 32) begin : g_bad_data_w
    $error("axil_regfile: C_DATA_W must be 32");
  end
  if (C_NUM_RW < 1 || C_NUM_RW > 64 || C_NUM_RO < 0 || C_NUM_RO > 64) begin : g_bad_count
    $error("axil_regfile: register counts out of range");
  end

  // Classify a full word index as RW, RO or unmapped.
  function automatic logic [1:0] decode_resp(input logic [WIDX_W-1:0] idx);
    if (idx < RW_END)       return RESP_OKAY;
    else if (idx < MAP_END) return RESP_SLVERR;
    else                    return RESP_DECERR;
  endfunction

  // Byte-lane merge of new data into an existing word.
  function automatic logic [C_DATA_W-1:0] merge_bytes(
    input logic [C_DATA_W-1:0] old_v,
    input logic [C_DATA_W-1:0] new_v,
    input logic [NBYTES-1:0]   strb
  );
    logic [C_DATA_W-1:0] r;
    r = old_v;
    for (int b = 0; b < NBYTES; b++) begin
      if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

  // The two byte-offset address bits carry no meaning for word registers.
  logic w_unused_addr_lsbs;
  assign w_unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // ---------------------------------------------------------------- write
  logic                  w_commit;
  logic [WIDX_W-1:0]     w_wr_idx;
  logic [C_DATA_W-1:0]   w_wr_data;
  logic [NBYTES-1:0]     w_wr_strb;
  logic [1:0]            w_wr_resp;

  assign w_wr_resp = decode_resp(w_wr_idx);

  axil_regfile_wr #(
    .C_DATA_W (C_DATA_W),
    .C_ADDR_W (C_ADDR_W)
  ) u_wr (
    .clk_i         (s_axi_aclk),
    .rst_i         (s_axi_areset),
    .awaddr_i      (s_axi_awaddr[C_ADDR_W-1:2]),
    .awvalid_i     (s_axi_awvalid),
    .awready_o     (s_axi_awready),
    .wdata_i       (s_axi_wdata),
    .wstrb_i       (s_axi_wstrb),
    .wvalid_i      (s_axi_wvalid),
    .wready_o      (s_axi_wready),
    .bresp_o       (s_axi_bresp),
    .bvalid_o      (s_axi_bvalid),
    .bready_i      (s_axi_bready),
    .commit_o      (w_commit),
    .commit_addr_o (w_wr_idx),
    .commit_data_o (w_wr_data),
    .commit_strb_o (w_wr_strb),
    .commit_resp_i (w_wr_resp)
  );

  // -------------------------------------------------------------- storage
  for (genvar gi = 0; gi < C_NUM_RW; gi++) begin : g_rw
    logic [C_DATA_W-1:0] reg_q;
    logic                stb_q;
    logic                w_hit;

    // Only indices below C_NUM_RW can match here, so a hit is always OKAY.
    assign w_hit = w_commit && (w_wr_idx == WIDX_W'(gi));

    // Control word with byte-merge on commit and a matching one-cycle strobe.
    always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
        reg_q <= '0;
        stb_q <= 1'b0;
      end else begin
        stb_q <= w_hit;
        if (w_hit) reg_q <= merge_bytes(reg_q, w_wr_data, w_wr_strb);
      end
    end

    assign ctrl_out[gi*C_DATA_W +: C_DATA_W] = reg_q;
    assign ctrl_wr_stb[gi]                   = stb_q;
  end

  // ----------------------------------------------------------------- read
  logic [WIDX_W-1:0]   w_rd_idx;
  logic [IDX_W-1:0]    w_rd_sel;
  logic [C_DATA_W-1:0] w_rd_data;
  logic [1:0]          w_rd_resp;
  logic                rvalid_q;
  logic [C_DATA_W-1:0] rdata_q;
  logic [1:0]          rresp_q;

  assign w_rd_idx = s_axi_araddr[C_ADDR_W-1:2];
  assign w_rd_sel = w_rd_idx[IDX_W-1:0];

  // Read mux; the narrow select is exact once the range check says mapped.
  // Control words come from the registers, so a same-edge write is not seen.
  always_comb begin
    w_rd_resp = decode_resp(w_rd_idx);
    w_rd_data = '0;
    for (int i = 0; i < C_NUM_RW; i++) begin
      if (w_rd_resp == RESP_OKAY && w_rd_sel == IDX_W'(i))
        w_rd_data = ctrl_out[i*C_DATA_W +: C_DATA_W];
    end
    for (int i = 0; i < C_NUM_RO; i++) begin
      if (w_rd_resp == RESP_SLVERR && w_rd_sel == IDX_W'(C_NUM_RW + i))
        w_rd_data = status_in[i*C_DATA_W +: C_DATA_W];
    end
    // Status words read back successfully; SLVERR only applies to writes.
    if (w_rd_resp == RESP_SLVERR) w_rd_resp = RESP_OKAY;
  end

  // R channel register: capture on AR handshake, hold until accepted.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (s_axi_arvalid && s_axi_arready) begin
      rvalid_q <= 1'b1;
      rdata_q  <= w_rd_data;
      rresp_q  <= w_rd_resp;
    end else if (rvalid_q && s_axi_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  assign s_axi_arready = !rvalid_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

endmodule
`default_nettype wire

// File: tb/tb_axil_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axil_regfile
//  Description : Directed bench for axil_regfile with a queue scoreboard for
//                B and R responses and inline checks on side-band outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_regfile;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NRW = 8;
  localparam int NRO = 4;

  logic              clk = 1'b0;
  logic              areset;
  logic [AW-1:0]     awaddr;
  logic              awvalid;
  logic              awready;
  logic [DW-1:0]     wdata;
  logic [DW/8-1:0]   wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [AW-1:0]     araddr;
  logic              arvalid;
  logic              arready;
  logic [DW-1:0]     rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [NRW*DW-1:0] ctrl_out;
  logic [NRW-1:0]    ctrl_wr_stb;
  logic [NRO*DW-1:0] status_in;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  logic [1:0] exp_b[$];
  rexp_t      exp_r[$];
  int n_total = 0;
  int n_pass  = 0;

  axil_regfile #(
    .C_DATA_W (DW), .C_ADDR_W (AW), .C_NUM_RW (NRW), .C_NUM_RO (NRO)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_areset  (areset),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .ctrl_out      (ctrl_out),
    .ctrl_wr_stb   (ctrl_wr_stb),
    .status_in     (status_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] word(input int i);
    return ctrl_out[i*32 +: 32];
  endfunction

  // Response monitor: one pop per B or R beat accepted at the next edge.
  always @(negedge clk) begin
    rexp_t er;
    logic [1:0] eb;
    if (!areset) begin
      if (bvalid && bready) begin
        if (exp_b.size() == 0) check("b_unexpected", {62'd0, bresp}, 64'hFF);
        else begin
          eb = exp_b.pop_front();
          check("bresp", {62'd0, bresp}, {62'd0, eb});
        end
      end
      if (rvalid && rready) begin
        if (exp_r.size() == 0) check("r_unexpected", {32'd0, rdata}, 64'hFFFF_FFFF_FFFF);
        else begin
          er = exp_r.pop_front();
          check("rdata", {32'd0, rdata}, {32'd0, er.data});
          check("rresp", {62'd0, rresp}, {62'd0, er.resp});
        end
      end
    end
  end

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] resp);
    int n;
    n = 0;
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
    exp_b.push_back(resp);
    while (!(awready && wready) && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("write_accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic do_aw(input logic [31:0] a, input logic [1:0] resp);
    int n;
    n = 0;
    awaddr = a; awvalid = 1'b1;
    exp_b.push_back(resp);
    while (!awready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("aw_accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] s);
    int n;
    n = 0;
    wdata = d; wstrb = s; wvalid = 1'b1;
    while (!wready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("w_accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
    int n;
    rexp_t e;
    n = 0;
    e.data = d; e.resp = resp;
    araddr = a; arvalid = 1'b1;
    exp_r.push_back(e);
    while (!arready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("ar_accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  // Boundary write table: last RW, last RO, first unmapped index.
  logic [31:0] tbl_addr [3] = '{32'h1C, 32'h2C, 32'h30};
  logic [1:0]  tbl_resp [3] = '{2'b00, 2'b10, 2'b11};

  initial begin
    areset = 1'b1; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b1; status_in = '0;
    repeat (3) @(posedge clk);
    #1 areset = 1'b0;
    @(negedge clk);
    check("rst_readies", {61'd0, awready, wready, arready}, 64'h7);
    check("rst_valids", {62'd0, bvalid, rvalid}, 64'h0);
    check("rst_ctrl", {63'd0, ctrl_out == '0}, 64'h1);
    check("rst_stb", {56'd0, ctrl_wr_stb}, 64'h0);

    // Simultaneous AW+W to word 1.
    do_write(32'h4, 32'hDEADBEEF, 4'hF, 2'b00);
    @(negedge clk);
    check("t1_bvalid", {63'd0, bvalid}, 64'h1);
    check("t1_word1", {32'd0, word(1)}, 64'hDEADBEEF);
    check("t1_stb", {56'd0, ctrl_wr_stb}, 64'h02);
    @(negedge clk);
    check("t1_stb_clear", {56'd0, ctrl_wr_stb}, 64'h00);
    do_read(32'h4, 32'hDEADBEEF, 2'b00);
    @(negedge clk);
    check("t1_rvalid", {63'd0, rvalid}, 64'h1);

    // W arrives three cycles ahead of AW, partial strobe.
    do_write(32'h0, 32'hFFFFFFFF, 4'hF, 2'b00);
    @(negedge clk);
    check("t2_prior", {32'd0, word(0)}, 64'hFFFFFFFF);
    do_w(32'h11223344, 4'h5);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t2_wready_low", {62'd0, wready, bvalid}, 64'h0);
    end
    check("t2_no_early_commit", {32'd0, word(0)}, 64'hFFFFFFFF);
    do_aw(32'h0, 2'b00);
    @(negedge clk);
    check("t2_merged", {32'd0, word(0)}, 64'hFF22FF44);
    check("t2_stb", {56'd0, ctrl_wr_stb}, 64'h01);

    // Writes to RO and unmapped space change nothing.
    do_write(32'h20, 32'h12345678, 4'hF, 2'b10);
    @(negedge clk);
    check("t3_ro_ctrl", ctrl_out[63:0], 64'hDEADBEEF_FF22FF44);
    check("t3_ro_stb", {56'd0, ctrl_wr_stb}, 64'h00);
    do_write(32'h40, 32'h12345678, 4'hF, 2'b11);
    @(negedge clk);
    check("t3_unm_ctrl", ctrl_out[63:0], 64'hDEADBEEF_FF22FF44);
    check("t3_unm_stb", {56'd0, ctrl_wr_stb}, 64'h00);

    // Zero strobe: OKAY, value kept, strobe still pulses.
    do_write(32'h4, 32'h0, 4'h0, 2'b00);
    @(negedge clk);
    check("t3_nostrb_word", {32'd0, word(1)}, 64'hDEADBEEF);
    check("t3_nostrb_stb", {56'd0, ctrl_wr_stb}, 64'h02);

    // Low address bits ignored: 0x0B lands in word 2.
    do_write(32'h0B, 32'h0000ABCD, 4'hF, 2'b00);
    @(negedge clk);
    check("t3_unaligned", {32'd0, word(2)}, 64'h0000ABCD);

    for (int k = 0; k < 3; k++) begin
      do_write(tbl_addr[k], 32'h5A5A0000 + k, 4'hF, tbl_resp[k]);
      @(negedge clk);
      check("t3_bound_stb", {56'd0, ctrl_wr_stb}, (k == 0) ? 64'h80 : 64'h00);
    end
    check("t3_word7", {32'd0, word(7)}, 64'h5A5A0000);

    // Reads: status sampled at the AR edge, unmapped, unaligned.
    status_in[63:32] = 32'hA5A5A5A5;
    status_in[31:0]  = 32'h13579BDF;
    do_read(32'h24, 32'hA5A5A5A5, 2'b00);
    status_in = '0;
    @(negedge clk);
    check("t4_rvalid", {63'd0, rvalid}, 64'h1);
    do_read(32'h40, 32'h0, 2'b11);
    do_read(32'h0B, 32'h0000ABCD, 2'b00);
    do_read(32'h1C, 32'h5A5A0000, 2'b00);

    // R held while rready low.
    @(posedge clk); #1 rready = 1'b0;
    do_read(32'h0, 32'hFF22FF44, 2'b00);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t4_r_hold", {30'd0, rvalid, arready, rdata}, {30'd0, 2'b10, 32'hFF22FF44});
    end
    @(posedge clk); #1 rready = 1'b1;

    // Read and write to the same word on the same edge.
    repeat (2) @(posedge clk); #1;
    fork
      do_write(32'h4, 32'h12345678, 4'hF, 2'b00);
      do_read(32'h4, 32'hDEADBEEF, 2'b00);
    join
    repeat (2) @(posedge clk); #1;
    do_read(32'h4, 32'h12345678, 2'b00);

    // B stall with bready low for ten cycles.
    @(posedge clk); #1 bready = 1'b0;
    do_write(32'h20, 32'h0, 4'hF, 2'b10);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("t5_b_stall", {59'd0, bvalid, bresp, awready, wready}, 64'b1_10_00);
    end
    @(posedge clk); #1 bready = 1'b1;

    // Reset with AW held and R pending; a same-edge W must not commit.
    repeat (2) @(posedge clk); #1;
    rready = 1'b0;
    araddr = 32'h0; arvalid = 1'b1;
    awaddr = 32'h8; awvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0; awvalid = 1'b0;
    @(negedge clk);
    check("t6_pre", {62'd0, rvalid, awready}, 64'b10);
    wdata = 32'h99999999; wstrb = 4'hF; wvalid = 1'b1; areset = 1'b1;
    @(posedge clk); #1;
    areset = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("t6_valids", {62'd0, bvalid, rvalid}, 64'h0);
    check("t6_resp_data", {28'd0, bresp, rresp, rdata}, 64'h0);
    check("t6_ctrl", {63'd0, ctrl_out == '0}, 64'h1);
    check("t6_stb", {56'd0, ctrl_wr_stb}, 64'h00);
    check("t6_readies", {61'd0, awready, wready, arready}, 64'h7);
    @(posedge clk); #1 rready = 1'b1;

    // A lone W after reset must wait: the old AW was discarded.
    do_w(32'h00000077, 4'hF);
    repeat (2) @(negedge clk);
    check("t6_w_waits", {31'd0, bvalid, word(2)}, 64'h0);
    do_aw(32'hC, 2'b00);
    @(negedge clk);
    check("t6_word3", {32'd0, word(3)}, 64'h77);
    check("t6_stb3", {56'd0, ctrl_wr_stb}, 64'h08);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_b.size() + exp_r.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion", n_total);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/axil_regfile.md
AXIL_REGFILE -- requirements
Module: axil_regfile

Interface
REQ-001 SHALL have parameter C_DATA_W, default 32, meaning AXI4-Lite data width (32 only; other values are a lint error).
REQ-002 SHALL have parameter C_ADDR_W, default 32, meaning AXI4-Lite address width.
REQ-003 SHALL have parameter C_NUM_RW, default 8, meaning count of read/write control registers (1..64).
REQ-004 SHALL have parameter C_NUM_RO, default 4, meaning count of read-only status registers (0..64).
REQ-005 SHALL have the following ports, in this order:
  s_axi_aclk  in  1  sole clock.
  s_axi_areset  in  1  synchronous active-high reset.
  s_axi_awaddr  in  C_ADDR_W  write address.
  s_axi_awvalid  in  1  / s_axi_awready  out  1  AW handshake.
  s_axi_wdata  in  C_DATA_W  write data.
  s_axi_wstrb  in  C_DATA_W/8  byte enables.
  s_axi_wvalid  in  1  / s_axi_wready  out  1  W handshake.
  s_axi_bresp  out  2  write response.
  s_axi_bvalid  out  1  / s_axi_bready  in  1  B handshake.
  s_axi_araddr  in  C_ADDR_W  read address.
  s_axi_arvalid  in  1  / s_axi_arready  out  1  AR handshake.
  s_axi_rdata  out  C_DATA_W  read data.
  s_axi_rresp  out  2  read response.
  s_axi_rvalid  out  1  / s_axi_rready  in  1  R handshake.
  ctrl_out  out  C_NUM_RW*C_DATA_W  control registers, register i at bits [i*C_DATA_W +: C_DATA_W].
  ctrl_wr_stb  out  C_NUM_RW  one-cycle pulse per register written.
  status_in  in  C_NUM_RO*C_DATA_W  status words, same packing as ctrl_out.

Function
REQ-006 SHALL decode word index = addr[C_ADDR_W-1:2]; addr[1:0] ignored; index 0..C_NUM_RW-1 is RW, C_NUM_RW..C_NUM_RW+C_NUM_RO-1 is RO, any higher index is unmapped.
REQ-007 SHALL accept AW and W independently: s_axi_awready = !aw_held && !s_axi_bvalid; s_axi_wready = !w_held && !s_axi_bvalid; each handshake latches the address or data+strobe.
REQ-008 SHALL commit on the first edge where AW and W are each either held or handshaking; with simultaneous AW+W handshake at edge N, ctrl_out and s_axi_bvalid update at edge N (visible in cycle N+1).
REQ-009 SHALL merge writes bytewise: byte b of the target register takes wdata byte b only where wstrb[b]=1; wstrb=0 leaves the register unchanged but still responds OKAY.
REQ-010 SHALL pulse ctrl_wr_stb[i] high for exactly the commit cycle (aligned with the ctrl_out update) on any OKAY write to RW register i.
REQ-011 SHALL set bresp: 2'b00 for an RW index, 2'b10 (SLVERR) for an RO index with no state change, 2'b11 (DECERR) for an unmapped index with no state change.
REQ-012 SHALL hold s_axi_bvalid and bresp stable until s_axi_bready; clear aw_held/w_held at commit; allow no new AW/W handshake while s_axi_bvalid=1.
REQ-013 SHALL set s_axi_arready = !s_axi_rvalid; on an AR handshake at edge N, register rdata/rresp and assert s_axi_rvalid in cycle N+1, holding both stable until s_axi_rready.
REQ-014 SHALL return the current ctrl word for an RW read and the status_in word sampled at the AR handshake edge for an RO read; unmapped reads return 0 with rresp 2'b11.
REQ-015 SHALL return the pre-commit value when a read and a write to the same register handshake on the same edge.
REQ-016 SHALL run read and write channels concurrently with no cross-channel stall.

Reset
REQ-017 SHALL, while s_axi_areset=1 at a rising edge, clear ctrl_out, ctrl_wr_stb, s_axi_bvalid, s_axi_rvalid, s_axi_bresp, s_axi_rresp, s_axi_rdata, aw_held and w_held to 0.
REQ-018 SHALL drive awready, wready and arready 1 in the first cycle after reset release.
REQ-019 SHALL discard any held AW/W or pending response on reset mid-transaction without a commit.

Structure
REQ-020 SHALL take response codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10 and RESP_DECERR=2'b11, plus the index-width function clog2(C_NUM_RW+C_NUM_RO), from shared package axil_pkg.
REQ-021 SHALL implement the AW/W capture, commit and B logic as a single sub-module, axil_regfile_wr; the read path, decode and storage stay in the top level.

Verification
REQ-022 SHALL cover: simultaneous AW+W to 0x4, wdata 0xDEADBEEF, wstrb 0xF -> bvalid next cycle with bresp 00, ctrl_out[63:32]=0xDEADBEEF, ctrl_wr_stb[1] high for one cycle.
REQ-023 SHALL cover: W three cycles before AW to 0x0, wdata 0x11223344, wstrb 0x5, prior value 0xFFFFFFFF -> wready low after W, reg0=0xFF22FF44 after AW.
REQ-024 SHALL cover: write to 0x20 (RO index 8) and 0x40 (index 16) with defaults -> bresp 10 and 11, ctrl_out unchanged, no strobe.
REQ-025 SHALL cover: read 0x24 with status_in word1=0xA5A5A5A5 -> rvalid next cycle, rdata 0xA5A5A5A5, rresp 00; read 0x40 -> rdata 0, rresp 11.
REQ-026 SHALL cover: bready held low 10 cycles -> bvalid and bresp stable, awready and wready low throughout.
REQ-027 SHALL cover: reset asserted with AW held and rvalid pending -> all outputs 0 next cycle, no commit, readies 1 after release.
